// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared widths, leaf count helper and loader state type
// for the adder-tree operand loader.
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 21;
  localparam int LEVELS_DEFAULT      = 3;

  function automatic int num_leaves(input int levels);
    return 1 << levels;
  endfunction

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/adder_tree_out_slot.sv
// adder_tree_out_slot: output batch register with valid/ready hold
// and a wrapping delivered-batch counter.
module adder_tree_out_slot #(
  parameter int DW = 168
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [15:0]   cnt_o,
  output logic          free_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          fire;

  assign fire    = valid_q && ready_i;
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

  // load wins over consume so a same-edge hand-over keeps valid high
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (fire) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + 16'd1;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/adder_tree_operand_loader.sv
// adder_tree_operand_loader: packs 2**LEVELS serial beats into one leaf vector.
// Optional early batch close with zero padding: ADDER_TREE_LOADER_FLUSH_EN.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEFAULT,
  parameter int LEVELS = LEVELS_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [WIDTH-1:0]                      in_data,
  input  logic                                  in_valid,
`ifdef ADDER_TREE_LOADER_FLUSH_EN
  input  logic                                  in_last,
`endif
  output logic                                  in_ready,
  output logic [num_leaves(LEVELS)*WIDTH-1:0]   out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [15:0]                           batch_cnt
);

  localparam int N  = num_leaves(LEVELS);
  localparam int DW = N * WIDTH;
  localparam logic [LEVELS-1:0] LAST_IDX = LEVELS'(N - 1);

  loader_state_e     state_q, state_d;
  logic [LEVELS-1:0] idx_q, idx_d;
  logic [DW-1:0]     fill_q, fill_d;
  logic [DW-1:0]     batch;
  logic [DW-1:0]     load_data;
  logic              last_beat;
  logic              load;
  logic              slot_free;

`ifdef ADDER_TREE_LOADER_FLUSH_EN
  assign last_beat = (idx_q == LAST_IDX) || in_last;
`else
  assign last_beat = (idx_q == LAST_IDX);
`endif

  // fill register as it would look with the current beat merged in
  always_comb begin
    batch = fill_q;
    for (int k = 0; k < N; k++) begin
      if (LEVELS'(k) == idx_q)
        batch[k*WIDTH +: WIDTH] = in_data;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
      else if (in_last && (LEVELS'(k) > idx_q))
        batch[k*WIDTH +: WIDTH] = '0;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    in_ready  = 1'b0;
    load      = 1'b0;
    load_data = batch;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fill_d = batch;
          idx_d  = idx_q + LEVELS'(1);
          if (last_beat) begin
            idx_d = '0;
            if (slot_free) load = 1'b1;
            else           state_d = HOLD;
          end
        end
      end
      HOLD: begin
        load_data = fill_q;
        if (slot_free) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
    end
  end

  adder_tree_out_slot #(
    .DW (DW)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .data_i  (load_data),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .cnt_o   (batch_cnt),
    .free_o  (slot_free)
  );

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// tb_adder_tree_operand_loader: scoreboard bench for the operand loader.
// Expected batches are queued on accepted beats and popped on delivery.
module tb_adder_tree_operand_loader;
  import adder_tree_pkg::*;

  localparam int W  = ADDER_WIDTH_DEFAULT;
  localparam int L  = LEVELS_DEFAULT;
  localparam int N  = num_leaves(L);
  localparam int DW = N * W;
`ifdef ADDER_TREE_LOADER_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   batch_cnt;

  always #5 clk = ~clk;

  adder_tree_operand_loader #(
    .WIDTH  (W),
    .LEVELS (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .batch_cnt (batch_cnt)
  );

  int            passes = 0;
  int            total = 0;
  logic [DW-1:0] expq[$];
  logic [W-1:0]  cur[N];
  int            cnt = 0;
  logic [15:0]   exp_bc = '0;
  bit            acc, fire, hold_prev, ok;
  logic [DW-1:0] prev;
  logic [DW-1:0] ones = '1;
  int            sent;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pack(input int n);
    logic [DW-1:0] v = '0;
    for (int k = 0; k < n; k++) v[k*W +: W] = cur[k];
    return v;
  endfunction

  task automatic clear_model();
    expq.delete();
    cnt = 0;
    exp_bc = '0;
    hold_prev = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [W-1:0] d,
                      input logic r, input logic l);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; in_last = l;
    #1;
    acc  = v && in_ready && rst_n;
    fire = out_valid && r && rst_n;
    if (rst_n) begin
      if (hold_prev) chk("stable", {out_valid, out_data}, {1'b1, prev});
      chk("batch_cnt", batch_cnt, exp_bc);
      if (fire) begin
        if (expq.size() == 0) chk("spurious", 1, 0);
        else chk("batch", out_data, expq.pop_front());
        exp_bc++;
      end
      hold_prev = out_valid && !r;
      prev = out_data;
    end
    if (acc) begin
      cur[cnt] = d;
      cnt++;
      if (cnt == N || (FL && l)) begin
        expq.push_back(pack(cnt));
        cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && expq.size() > 0; i++) tick(0, '0, 1, 0);
    if (expq.size() != 0) chk("drain_timeout", 0, 1);
    tick(0, '0, 1, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", batch_cnt, 0);
    chk("rst_rdy", in_ready, 1);

    // back-to-back batch with a free output slot
    ok = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick(1, W'(j), 1, 0);
      ok &= acc;
      if (j == 8) chk("t1_pre_valid", out_valid, 0);
    end
    tick(0, '0, 1, 0);
    ok &= in_ready;
    chk("t1_valid", out_valid, 1);
    chk("t1_slot0", out_data[W-1:0], 1);
    chk("t1_slot7", out_data[DW-1 -: W], 8);
    tick(0, '0, 1, 0);
    chk("t1_cnt", batch_cnt, 1);
    chk("t1_rdy", ok, 1);

    // second batch fills behind a stalled slot, then HOLD
    do_reset();
    ok = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick(1, W'(100 + j), 0, 0);
      ok &= acc;
    end
    chk("t2_fill", ok, 1);
    tick(1, W'(117), 0, 0);
    chk("t2_hold_rdy", in_ready, 0);
    tick(1, W'(117), 1, 0);
    chk("t2_hold_rdy2", in_ready, 0);
    tick(1, W'(117), 1, 0);
    chk("t2_b2_valid", out_valid, 1);
    chk("t2_rdy_back", in_ready, 1);
    for (int j = 18; j <= 24; j++) tick(1, W'(100 + j), 1, 0);
    drain();
    chk("t2_cnt", batch_cnt, 3);

    // all-ones operands pass bit-exact
    do_reset();
    for (int j = 0; j < 8; j++) tick(1, 21'h1FFFFF, 1, 0);
    tick(0, '0, 1, 0);
    chk("t3_ones", out_data, ones);
    tick(0, '0, 1, 0);

    // asynchronous reset mid-batch
    do_reset();
    for (int j = 0; j < 8; j++) tick(1, W'(j + 32), 0, 0);
    for (int j = 0; j < 5; j++) tick(1, W'(j + 64), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_valid", out_valid, 0);
    chk("t4_rdy", in_ready, 1);
    chk("t4_data", out_data, 0);
    clear_model();
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 0);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) tick(1, W'(16 + j), 1, 0);
    tick(0, '0, 0, 0);
    chk("t4_slot0", out_data[W-1:0], 21'h10);
    chk("t4_cnt", batch_cnt, 0);
    drain();

    // random handshake traffic
    do_reset();
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      tick(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 0);
      if (acc) sent++;
    end
    chk("t5_sent", sent, 1000);
    drain();
    chk("t5_cnt", batch_cnt, 125);

`ifdef ADDER_TREE_LOADER_FLUSH_EN
    // early close with zero padding
    do_reset();
    tick(1, W'(5), 1, 0);
    tick(1, W'(6), 1, 0);
    tick(1, W'(7), 1, 1);
    tick(0, '0, 1, 0);
    chk("t6_slot0", out_data[0 +: W], 5);
    chk("t6_slot1", out_data[W +: W], 6);
    chk("t6_slot2", out_data[2*W +: W], 7);
    chk("t6_pad", out_data[DW-1:3*W], 0);
    for (int j = 1; j <= 8; j++) tick(1, W'(j), 1, 0);
    tick(0, '0, 0, 0);
    chk("t6_next0", out_data[W-1:0], 1);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/adder_tree_operand_loader.md
Name: adder_tree_operand_loader

Overview:
- Producer-side front end for the adder-tree benchmarks: accepts a serial stream of WIDTH-bit operands over valid/ready and packs every 2**LEVELS beats into one parallel operand vector for the adder tree's leaf inputs.
- Holds a fill register and an output register, so the stream runs at full rate while the tree side stalls for up to one batch.

Parameters:
- WIDTH, 21, operand width in bits; matches the tree's leaf width.
- LEVELS, 3, tree depth; batch size N = 2**LEVELS (8 by default).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  serial operand.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a beat this cycle.
- out_data  out  N*WIDTH  packed batch; operand k (k-th beat of the batch, k=0 first) at [k*WIDTH +: WIDTH]; k=0 drives leaf isum0_0_0_0 and k=N-1 drives leaf isum0_1_1_1.
- out_valid  out  1  out_data holds a complete batch.
- out_ready  in  1  tree side consumes the batch.
- batch_cnt  out  16  batches delivered (out_valid && out_ready); wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - out_valid=0, out_data=0, batch_cnt=0.
  - Fill index=0, state=FILL, in_ready=1 the first cycle after reset.
- Beat accepted on in_valid && in_ready: data written to fill slot idx, idx increments.
- States:
  - FILL: in_ready=1. On accepting the beat with idx==N-1, the batch goes to the output register at that same edge if the slot is free (!out_valid || out_ready), and idx returns to 0. Otherwise go to HOLD, with the last beat stored in the fill register.
  - HOLD: in_ready=0. When !out_valid || out_ready, transfer the fill register to the output, set idx=0, go to FILL.
- Latency: out_valid rises the cycle after the N-th beat is accepted (1 cycle), or the cycle after the slot frees in HOLD.
- Throughput: 1 beat/cycle sustained when out_ready is held high. No bubble at batch boundaries.
- Output register:
  - out_valid stays high and out_data is stable until out_ready.
  - A same-edge consume plus new transfer keeps out_valid=1 with the new data.
  - A consume with no transfer clears out_valid. out_data keeps its value.
- Arithmetic: no arithmetic on data; bits pass through unchanged. idx is a LEVELS-bit counter (wraps naturally, N-1 -> 0).
- Boundary conditions:
  - in_valid with in_ready=0: no effect; the upstream must hold its data.
  - out_ready with out_valid=0: ignored; batch_cnt does not change.
  - Reset mid-batch: partial fill is discarded; the first beat after reset is operand 0.

Optional Feature:
- Macro ADDER_TREE_LOADER_FLUSH_EN.
- Defined:
  - Adds input port in_last (1 bit). A beat accepted with in_last=1 closes the batch early: remaining slots idx+1..N-1 are zero-filled, and transfer/HOLD rules apply as for the N-th beat.
  - in_last on the N-th beat is the same as a normal completion.
  - Zero padding keeps the tree sum correct for short batches.
- Not defined: no in_last port; a batch completes only after exactly N beats.

Decomposition:
- Shared package adder_tree_pkg:
  - ADDER_WIDTH_DEFAULT=21, LEVELS_DEFAULT=3.
  - function num_leaves(levels) = 1<<levels.
  - Loader state enum {FILL, HOLD}.
- One natural sub-module: adder_tree_out_slot, the output register with its valid/ready hold and batch_cnt.
- Fill register, index and FSM stay in the top.

Test Plan:
- Reset, then 8 beats 1..8 back-to-back with out_ready=1 -> out_valid=1 exactly one cycle after beat 8. out_data[20:0]=1, out_data[167:147]=8. batch_cnt=1 the cycle after. in_ready never drops.
- 24 beats continuous, out_ready=0 after the first batch is presented -> batch 2 fills. in_ready drops the cycle after beat 16 (HOLD). Raise out_ready -> batch 1 is consumed and batch 2 appears next cycle. in_ready=1 again the following cycle. Final batch_cnt=3 after all are drained.
- Operand 0x1FFFFF in all 8 slots -> out_data all-ones across 168 bits, bit-exact (no sign/width alteration).
- Assert rst_n=0 asynchronously after 5 beats, mid-cycle -> out_valid=0 and in_ready=1 immediately. Then 8 new beats 0x10..0x17 -> slot 0 = 0x10.
- Random in_valid/out_ready toggling, 1000 beats -> scoreboard: every beat appears once, in order. out_data is stable while out_valid && !out_ready. batch_cnt=125.
- With ADDER_TREE_LOADER_FLUSH_EN: beats 5,6,7 with in_last on 7 -> slots 0..2 = 5,6,7, slots 3..7 = 0. The next batch starts at slot 0.
